// File: rtl/cba_stream_ctrl.sv
// cba_stream_ctrl: stream front-end for a fixed-point processor.
// The block has three parts:
//   - An input sample FIFO.
//   - A FILL/RUN/DONE sequencer. It holds the processor in reset until the
//     FIFO is primed, and it frames the results into blocks of FRAME_LEN.
//   - A single-entry result register toward downstream.
// Optional feature: define CBA_STREAM_CTRL_STATS_EN to build the saturating
// err_cnt statistics counter. Without it, err_cnt is tied to zero.
module cba_stream_ctrl #(
    parameter int DW        = 31,
    parameter int DEPTH     = 8,
    parameter int PRIME_LVL = 4,
    parameter int FRAME_LEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          proc_rst,
    output logic [DW-1:0] proc_in,
    input  logic [1:0]    proc_req,
    input  logic [DW-1:0] proc_out,
    input  logic [1:0]    proc_out_en,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          frame_done,
    output logic          underrun,
    output logic          overrun,
    output logic [15:0]   res_cnt,
    output logic [15:0]   err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] PRIME_C = PRIME_LVL[AW:0];
    localparam logic [15:0] FRAME_C = FRAME_LEN[15:0];

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic          push;
    logic          pop;
    logic          req;
    logic          starve;
    logic          res_en;
    logic          res_load;
    logic          res_drop;
    logic [15:0]   res_next;
    logic          frame_end;

    // Occupancy comes only from registered state, so s_ready never depends
    // combinationally on the current inputs. There is no read bypass either:
    // a request against an empty FIFO is a starve, even if a push lands in
    // the same cycle.
    assign s_ready   = (count < DEPTH_C);
    assign push      = s_valid && s_ready;
    assign req       = (state == RUN) && (proc_req == 2'd1);
    assign pop       = req && (count != '0);
    assign starve    = req && (count == '0);

    // A result strobe always counts toward the frame. It is either loaded or
    // dropped, depending on whether the output slot is free this cycle.
    assign res_en    = (state == RUN) && (proc_out_en == 2'd1);
    assign res_load  = res_en && (!m_valid || m_ready);
    assign res_drop  = res_en && m_valid && !m_ready;
    assign res_next  = res_cnt + 16'd1;
    assign frame_end = res_en && (res_next == FRAME_C);

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. proc_rst stays asserted everywhere except RUN.
    always_comb begin
        state_nxt  = state;
        proc_rst   = 1'b1;
        frame_done = 1'b0;
        case (state)
            FILL: begin
                if (count >= PRIME_C) state_nxt = RUN;
            end
            RUN: begin
                proc_rst = 1'b0;
                if (frame_end) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is
    // a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. It needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // Sample register toward the processor. It holds until the next request
    // in RUN, and it is zeroed when a request finds the FIFO empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            proc_in <= '0;
        end else if (pop) begin
            proc_in <= mem[rd_ptr];
        end else if (starve) begin
            proc_in <= '0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (starve)   underrun <= 1'b1;
            if (res_drop) overrun  <= 1'b1;
        end
    end

    // Result slot and per-frame result counter. When a reload happens in the
    // same cycle as a consume, the slot stays valid with the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            res_cnt <= '0;
        end else begin
            if (res_load) begin
                m_data  <= proc_out;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (res_en) res_cnt <= frame_end ? 16'd0 : res_next;
        end
    end

`ifdef CBA_STREAM_CTRL_STATS_EN
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_cnt} + {16'd0, starve} + {16'd0, res_drop};

    // Error event counter. A starve and a drop in the same cycle add two;
    // the counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cba_stream_ctrl.sv
// Bench for cba_stream_ctrl. A queue-based reference model tracks the
// expected outputs. It is compared every cycle, and directed scenarios add
// literal expectations. Randomized traffic follows the directed part.
module tb_cba_stream_ctrl;

    localparam int DW    = 31;
    localparam int DEPTH = 8;
    localparam int PRIME = 4;
    localparam int FLEN  = 4;
`ifdef CBA_STREAM_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          proc_rst;
    logic [DW-1:0] proc_in;
    logic [1:0]    proc_req;
    logic [DW-1:0] proc_out;
    logic [1:0]    proc_out_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          frame_done;
    logic          underrun;
    logic          overrun;
    logic [15:0]   res_cnt;
    logic [15:0]   err_cnt;

    cba_stream_ctrl #(
        .DW(DW), .DEPTH(DEPTH), .PRIME_LVL(PRIME), .FRAME_LEN(FLEN)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .proc_rst(proc_rst), .proc_in(proc_in),
        .proc_req(proc_req), .proc_out(proc_out), .proc_out_en(proc_out_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_done(frame_done), .underrun(underrun), .overrun(overrun),
        .res_cnt(res_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model. phase: 0 = priming, 1 = processing, 2 = frame-end cycle.
    logic [DW-1:0] q[$];
    int            phase;
    logic [DW-1:0] e_pin;
    logic [DW-1:0] e_md;
    bit            e_mv;
    bit            e_und;
    bit            e_ovr;
    int            e_rc;
    int            e_ec;
    bit            model_on = 1'b0;

    always @(posedge clk) begin
        int  occ;
        int  nphase;
        int  ev;
        if (rst) begin
            q.delete();
            phase = 0;
            e_pin = '0; e_md = '0; e_mv = 0; e_und = 0; e_ovr = 0;
            e_rc = 0; e_ec = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            occ    = q.size();
            nphase = phase;
            ev     = 0;
            if (phase == 0) begin
                if (occ >= PRIME) nphase = 1;
            end else if (phase == 2) begin
                nphase = 0;
            end
            if (phase == 1 && proc_req == 2'd1) begin
                if (occ > 0) begin
                    e_pin = q.pop_front();
                end else begin
                    e_pin = '0;
                    e_und = 1;
                    ev++;
                end
            end
            if (phase == 1 && proc_out_en == 2'd1) begin
                if (!e_mv || m_ready) begin
                    e_md = proc_out;
                    e_mv = 1;
                end else begin
                    e_ovr = 1;
                    ev++;
                end
                e_rc++;
                if (e_rc == FLEN) begin
                    e_rc   = 0;
                    nphase = 2;
                end
            end else if (e_mv && m_ready) begin
                e_mv = 0;
            end
            if (s_valid && occ < DEPTH) q.push_back(s_data);
            if (STATS) e_ec = (e_ec + ev > 65535) ? 65535 : e_ec + ev;
            phase = nphase;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m.s_ready",    DW'(s_ready),    DW'(q.size() < DEPTH));
            chk("m.proc_rst",   DW'(proc_rst),   DW'(phase != 1));
            chk("m.proc_in",    proc_in,         e_pin);
            chk("m.m_data",     m_data,          e_md);
            chk("m.m_valid",    DW'(m_valid),    DW'(e_mv));
            chk("m.frame_done", DW'(frame_done), DW'(phase == 2));
            chk("m.underrun",   DW'(underrun),   DW'(e_und));
            chk("m.overrun",    DW'(overrun),    DW'(e_ovr));
            chk("m.res_cnt",    DW'(res_cnt),    DW'(e_rc));
            chk("m.err_cnt",    DW'(err_cnt),    DW'(e_ec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] stat(input int n);
        return STATS ? DW'(n) : '0;
    endfunction

    initial begin
        rst = 1'b1; s_valid = 0; s_data = '0; proc_req = 2'd0;
        proc_out = '0; proc_out_en = 2'd0; m_ready = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst.proc_rst", DW'(proc_rst), DW'(1));
        chk("rst.s_ready",  DW'(s_ready),  DW'(1));
        chk("rst.m_valid",  DW'(m_valid),  DW'(0));
        chk("rst.proc_in",  proc_in,       '0);
        chk("rst.res_cnt",  DW'(res_cnt),  '0);
        chk("rst.err_cnt",  DW'(err_cnt),  '0);
        rst = 1'b0;

        // Priming
        push_one(DW'(5));
        push_one(DW'(-7));
        push_one(DW'(100));
        tick();
        chk("prime.three", DW'(proc_rst), DW'(1));
        push_one(DW'(42));
        chk("prime.four_same_edge", DW'(proc_rst), DW'(1));
        tick();
        chk("prime.released", DW'(proc_rst), DW'(0));

        // Sample delivery, followed by an underrun
        proc_req = 2'd1;
        tick(); chk("deliv.5",   proc_in, DW'(5));
        tick(); chk("deliv.m7",  proc_in, DW'(-7));
        tick(); chk("deliv.100", proc_in, DW'(100));
        tick(); chk("deliv.42",  proc_in, DW'(42));
        tick();
        proc_req = 2'd0;
        chk("under.proc_in", proc_in,        '0);
        chk("under.flag",    DW'(underrun),  DW'(1));
        chk("under.err_cnt", DW'(err_cnt),   stat(1));

        // Fill the FIFO completely
        for (int i = 1; i <= 8; i++) push_one(DW'(i));
        chk("full.s_ready", DW'(s_ready), DW'(0));

        // Backpressure
        m_ready = 1'b0; proc_out_en = 2'd1; proc_out = DW'(11);
        tick();
        proc_out = DW'(22);
        tick();
        proc_out_en = 2'd0;
        chk("bp.m_data",  m_data,        DW'(11));
        chk("bp.m_valid", DW'(m_valid),  DW'(1));
        chk("bp.overrun", DW'(overrun),  DW'(1));
        chk("bp.res_cnt", DW'(res_cnt),  DW'(2));
        chk("bp.err_cnt", DW'(err_cnt),  stat(2));

        // Frame end
        m_ready = 1'b1; proc_out_en = 2'd1; proc_out = DW'(33);
        tick();
        chk("fe.m_data33", m_data,       DW'(33));
        chk("fe.res3",     DW'(res_cnt), DW'(3));
        proc_out = DW'(44);
        tick();
        proc_out_en = 2'd0; m_ready = 1'b0;
        chk("fe.frame_done", DW'(frame_done), DW'(1));
        chk("fe.proc_rst",   DW'(proc_rst),   DW'(1));
        chk("fe.res_cnt",    DW'(res_cnt),    DW'(0));
        chk("fe.m_data44",   m_data,          DW'(44));
        chk("fe.fifo_full",  DW'(s_ready),    DW'(0));
        tick();
        chk("fe.pulse_end", DW'(frame_done), DW'(0));
        chk("fe.fill",      DW'(proc_rst),   DW'(1));
        tick();
        chk("fe.rerun", DW'(proc_rst), DW'(0));
        proc_req = 2'd1;
        tick(); chk("fe.kept1", proc_in, DW'(1));
        tick(); chk("fe.kept2", proc_in, DW'(2));
        proc_req = 2'd0;
        chk("mr.pre_mvalid", DW'(m_valid), DW'(1));

        // Mid-frame reset with 6 samples queued and a pending result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr.proc_rst",   DW'(proc_rst),   DW'(1));
        chk("mr.proc_in",    proc_in,         '0);
        chk("mr.m_data",     m_data,          '0);
        chk("mr.m_valid",    DW'(m_valid),    DW'(0));
        chk("mr.frame_done", DW'(frame_done), DW'(0));
        chk("mr.underrun",   DW'(underrun),   DW'(0));
        chk("mr.overrun",    DW'(overrun),    DW'(0));
        chk("mr.res_cnt",    DW'(res_cnt),    DW'(0));
        chk("mr.err_cnt",    DW'(err_cnt),    DW'(0));
        chk("mr.s_ready",    DW'(s_ready),    DW'(1));

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            s_valid     = $urandom_range(0, 1);
            s_data      = DW'($urandom);
            proc_req    = 2'($urandom_range(0, 3));
            proc_out_en = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'($urandom_range(0, 3));
            proc_out    = DW'($urandom);
            m_ready     = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cba_stream_ctrl.md
CBA_STREAM_CTRL -- requirements
Module: cba_stream_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  DW, 31, sample and result width, signed two's complement.
  DEPTH, 8, input FIFO depth, power of two, minimum 4.
  PRIME_LVL, 4, FIFO occupancy required before the processor is released from reset, range 1..DEPTH.
  FRAME_LEN, 256, results per frame, range 1..65535.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk  in  1  single clock; all logic on the rising edge.
  rst  in  1  synchronous, active-high reset.
  s_data  in  DW  upstream sample.
  s_valid  in  1  upstream sample valid.
  s_ready  out  1  FIFO can accept a sample.
  proc_rst  out  1  reset to the fixed-point processor.
  proc_in  out  DW  sample presented to the processor.
  proc_req  in  2  processor sample request; 2'd1 means request, any other value means idle.
  proc_out  in  DW  processor result.
  proc_out_en  in  2  processor result strobe; 2'd1 means valid, any other value means idle.
  m_data  out  DW  result to downstream.
  m_valid  out  1  m_data holds an unconsumed result.
  m_ready  in  1  downstream accepts the result.
  frame_done  out  1  one-cycle pulse at end of frame.
  underrun  out  1  sticky flag: a request arrived while the FIFO was empty.
  overrun  out  1  sticky flag: a result was dropped.
  res_cnt  out  16  results accepted in the current frame.
  err_cnt  out  16  statistics counter (see REQ-019).

Function
REQ-003 A sample SHALL be written to the FIFO when s_valid && s_ready; s_ready SHALL equal (occupancy < DEPTH), computed combinationally from registered state.
REQ-004 The FSM SHALL have three states: FILL, RUN, DONE; reset enters FILL.
REQ-005 FILL SHALL drive proc_rst=1 and SHALL move to RUN on the first clock edge at which occupancy >= PRIME_LVL.
REQ-006 RUN SHALL drive proc_rst=0.
REQ-007 In RUN, when proc_req==2'd1 and the FIFO is non-empty, the head SHALL be popped and appear on proc_in one clock later, held until the next pop.
REQ-008 In RUN, when proc_req==2'd1 and the FIFO is empty, there SHALL be no pop, proc_in SHALL be driven 0 from the next clock, and underrun SHALL set.
REQ-009 proc_req SHALL be ignored outside RUN.
REQ-010 A push and a pop in the same cycle SHALL leave occupancy unchanged and are legal when full or empty-with-push; pop-with-push on an empty FIFO counts as underrun because FIFO output is not combinationally bypassed.
REQ-011 In RUN, when proc_out_en==2'd1 and (!m_valid || m_ready), m_data SHALL load proc_out, m_valid SHALL become 1 and res_cnt SHALL increment.
REQ-012 When proc_out_en==2'd1 with m_valid && !m_ready, the result SHALL be dropped, m_data SHALL be kept, overrun SHALL set, and res_cnt SHALL still increment.
REQ-013 m_valid SHALL clear on m_valid && m_ready unless REQ-011 reloads it in the same cycle.
REQ-014 When res_cnt reaches FRAME_LEN, the FSM SHALL move to DONE on the same edge, with res_cnt cleared to 0.
REQ-015 DONE SHALL last exactly one cycle, with frame_done=1 and proc_rst=1, then move to FILL; the FIFO contents SHALL be preserved.
REQ-016 Result latency from a proc_out_en strobe to m_valid SHALL be one clock.

Reset
REQ-017 Synchronous rst SHALL force, on the next edge and overriding all other events:
  FSM = FILL, FIFO empty, proc_rst=1, proc_in=0;
  m_data=0, m_valid=0, frame_done=0;
  underrun=0, overrun=0, res_cnt=0, err_cnt=0.
REQ-018 Reset asserted mid-frame SHALL discard the FIFO contents and any pending result.

Configuration
REQ-019 With macro CBA_STREAM_CTRL_STATS_EN defined, err_cnt SHALL increment, saturating at 16'hFFFF, once per underrun event and once per overrun event; when both occur in the same cycle it SHALL increment by 2, saturating.
REQ-020 Without CBA_STREAM_CTRL_STATS_EN, err_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; the sticky flags are unaffected either way.

Verification
REQ-021 The bench SHALL cover the following scenarios:
  Priming: push 3 samples -> proc_rst stays 1; push a 4th -> proc_rst=0 on the next edge.
  Sample delivery: samples 5, -7, 100 pushed; three proc_req=2'd1 in RUN -> proc_in = 5, -7, 100, each one clock after its request.
  Underrun: proc_req=2'd1 with the FIFO empty -> proc_in=0, underrun=1, err_cnt=1 (STATS_EN).
  Backpressure: m_ready=0; two proc_out_en strobes with results 11 and 22 -> m_data=11, overrun=1, res_cnt=2.
  Frame end: FRAME_LEN=4, four results accepted -> frame_done pulses for 1 cycle, proc_rst=1, FSM in FILL, res_cnt=0, FIFO occupancy unchanged.
  Mid-frame reset: rst asserted with FIFO holding 6 samples and m_valid=1 -> all outputs match REQ-017 on the next edge, s_ready=1.
